top_a1_q4_seq_dec_3x8: RTL and testbench

//   Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides.

---
 rtl/a1_dec_pkg.sv | 21 ++
 rtl/pri_enc_8x3_chk.sv | 17 +
 rtl/top_a1_q4_seq_dec_3x8.sv | 139 +++++++++++++
 tb/tb_top_a1_q4_seq_dec_3x8.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a1_dec_pkg.sv
// Shared definitions for the sequenced 3-to-8 decoder: FSM states, code and
// one-hot widths, and the code-to-one-hot helper.
package a1_dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DWELL   = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] v;
    v       = {ONEHOT_W{1'b0}};
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pri_enc_8x3_chk.sv
// Gate-level 8x3 priority encoder (highest set bit wins) used to re-encode the
// decoder output for the loopback check; any flags a non-zero input.
module pri_enc_8x3_chk
  import a1_dec_pkg::*;
(
  input  logic [ONEHOT_W-1:0] o,
  output logic [CODE_W-1:0]   code,
  output logic                any
);

  assign code[2] = o[7] | o[6] | o[5] | o[4];
  assign code[1] = o[7] | o[6] | (~o[5] & ~o[4] & (o[3] | o[2]));
  assign code[0] = o[7] | (~o[6] & o[5]) | (~o[6] & ~o[4] & o[3])
                 | (~o[6] & ~o[4] & ~o[2] & o[1]);
  assign any     = |o;

endmodule

// File: rtl/top_a1_q4_seq_dec_3x8.sv
// Registered 3-to-8 one-hot decoder with valid/ready on both sides and a
// programmable minimum dwell. Optional loopback checker: SEQ_DEC_LOOPBACK_EN.
module top_a1_q4_seq_dec_3x8
  import a1_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   in_code,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] O,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
`ifdef SEQ_DEC_LOOPBACK_EN
  output logic [CNT_W-1:0]    acc_cnt,
  output logic                lb_err
`else
  output logic [CNT_W-1:0]    acc_cnt
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(HOLD_CYCLES - 1);
  localparam state_e LOAD_STATE = (HOLD_CYCLES == 0) ? S_PRESENT : S_DWELL;

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [CNT_W-1:0]    acc_cnt_r, acc_cnt_s;
  logic [ONEHOT_W-1:0] o_r, o_s;
  logic                out_valid_r;
  logic                busy_r;
  logic                in_ready_s;
  logic                accept_s;

  // Next-state, dwell count, one-hot load and accept counting
  always_comb begin
    in_ready_s = (state_r == S_IDLE) || ((state_r == S_PRESENT) && out_ready);
    accept_s   = in_valid && in_ready_s;
    state_s    = state_r;
    cnt_s      = cnt_r;
    o_s        = o_r;
    case (state_r)
      S_IDLE: begin
        state_s = S_IDLE;
      end
      S_DWELL: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = S_PRESENT;
        end else begin
          cnt_s = cnt_r - CNT_W'(1'b1);
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          state_s = S_IDLE;
          o_s     = {ONEHOT_W{1'b0}};
        end else begin
          state_s = S_PRESENT;
        end
      end
      default: begin
        state_s = S_IDLE;
        o_s     = {ONEHOT_W{1'b0}};
      end
    endcase
    // An accept overrides the handoff so a pass-through never shows a zero cycle
    if (accept_s) begin
      state_s   = LOAD_STATE;
      cnt_s     = HOLD_LOAD;
      o_s       = onehot(in_code);
      acc_cnt_s = acc_cnt_r + CNT_W'(1'b1);
    end else begin
      acc_cnt_s = acc_cnt_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_cnt_r   <= {CNT_W{1'b0}};
      o_r         <= {ONEHOT_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      acc_cnt_r   <= acc_cnt_s;
      o_r         <= o_s;
      out_valid_r <= (state_s == S_PRESENT);
      busy_r      <= (state_s != S_IDLE);
    end
  end

  assign in_ready  = in_ready_s;
  assign O         = o_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign acc_cnt   = acc_cnt_r;

`ifdef SEQ_DEC_LOOPBACK_EN
  logic [CODE_W-1:0] code_r;
  logic [CODE_W-1:0] enc_code_s;
  logic              enc_any_s;
  logic              lb_err_r;

  pri_enc_8x3_chk u_pri_enc_chk (
    .o    (o_r),
    .code (enc_code_s),
    .any  (enc_any_s)
  );

  // Latch of the accepted code, reference for the loopback compare
  always_ff @(posedge clk) begin
    if (rst) begin
      code_r <= {CODE_W{1'b0}};
    end else if (accept_s) begin
      code_r <= in_code;
    end
  end

  // Sticky loopback error: O must re-encode to the latched code while active
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_err_r <= 1'b0;
    end else if ((state_r != S_IDLE) && (!enc_any_s || (enc_code_s != code_r))) begin
      lb_err_r <= 1'b1;
    end
  end

  assign lb_err = lb_err_r;
`endif

endmodule

// File: tb/tb_top_a1_q4_seq_dec_3x8.sv
// Self-checking bench for top_a1_q4_seq_dec_3x8: directed scenarios plus a
// randomized run against a transaction-level model (active code + age).
module tb_top_a1_q4_seq_dec_3x8;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_ready;
  logic [7:0] O;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic [7:0] acc_cnt;
`ifdef SEQ_DEC_LOOPBACK_EN
  logic       lb_err;
`endif

  int checks = 0;
  int errors = 0;

  // model: is a code being held, which code, cycles since it was accepted
  bit m_active = 1'b0;
  int m_code = 0;
  int m_age = 0;
  int m_acc = 0;
  bit exp_in_ready;
  logic seen_in_ready;

  top_a1_q4_seq_dec_3x8 #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .O         (O),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef SEQ_DEC_LOOPBACK_EN
    .acc_cnt   (acc_cnt),
    .lb_err    (lb_err)
`else
    .acc_cnt   (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_o();
    logic [7:0] v;
    v = 8'h00;
    if (m_active) v = 8'(1 << m_code);
    return v;
  endfunction

  // drive one cycle, sample in_ready before the edge, advance the model
  task automatic tick(input logic r, input logic iv, input logic [2:0] c, input logic ordy);
    rst = r; in_valid = iv; in_code = c; out_ready = ordy;
    #1;
    exp_in_ready  = !m_active || (m_age >= HOLD && ordy);
    seen_in_ready = in_ready;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_age = 0; m_acc = 0;
    end else if (iv && exp_in_ready) begin
      m_active = 1'b1; m_code = int'(c); m_age = 0; m_acc = (m_acc + 1) % 256;
    end else if (m_active && m_age >= HOLD && ordy) begin
      m_active = 1'b0;
    end else if (m_active && m_age < HOLD) begin
      m_age++;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    checks++;
    if (O !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || acc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: O=%h ov=%b busy=%b acc=%0d, required 00/0/0/0", O, out_valid, busy, acc_cnt);
    end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_single();
    tick(1'b0, 1'b1, 3'd5, 1'b1);
    checks++;
    if (O !== 8'h20 || O !== exp_o() || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_load: O=%h ov=%b, required 20/0", O, out_valid);
    end
    for (int k = 1; k <= HOLD; k++) begin
      tick(1'b0, 1'b0, 3'd0, 1'b0);
      checks++;
      if (out_valid !== (k == HOLD) || O !== 8'h20) begin
        errors++;
        $display("FAIL single_dwell%0d: ov=%b O=%h, required %b/20", k, out_valid, O, (k == HOLD));
      end
    end
    tick(1'b0, 1'b0, 3'd0, 1'b1);
    checks++;
    if (O !== 8'h00 || out_valid !== 1'b0 || acc_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_handoff: O=%h ov=%b acc=%0d busy=%b, required 00/0/1/0", O, out_valid, acc_cnt, busy);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] want;
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      want = 8'h01 << i;
      tick(1'b0, 1'b1, 3'(i), 1'b1);
      checks++;
      if (O !== want) begin
        errors++;
        $display("FAIL sweep_code%0d: O=%h, required %h", i, O, want);
      end
      for (int k = 0; k <= HOLD; k++) tick(1'b0, 1'b0, 3'd0, 1'b1);
    end
    checks++;
    if (acc_cnt !== 8'd8 || O !== 8'h00) begin
      errors++;
      $display("FAIL sweep_count: acc=%0d O=%h, required 8/00", acc_cnt, O);
    end
  endtask

  task automatic test_back_to_back();
    int acc0;
    tick(1'b0, 1'b1, 3'd3, 1'b0);
    for (int k = 0; k < HOLD; k++) tick(1'b0, 1'b0, 3'd0, 1'b0);
    checks++;
    if (O !== 8'h08 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_present: O=%h ov=%b, required 08/1", O, out_valid);
    end
    acc0 = int'(acc_cnt);
    tick(1'b0, 1'b1, 3'd6, 1'b1);
    checks++;
    if (seen_in_ready !== 1'b1 || O !== 8'h40 || out_valid !== 1'b0 || busy !== 1'b1
        || int'(acc_cnt) != (acc0 + 1) % 256) begin
      errors++;
      $display("FAIL b2b_pass: rdy=%b O=%h ov=%b busy=%b acc=%0d, required 1/40/0/1/%0d",
               seen_in_ready, O, out_valid, busy, acc_cnt, (acc0 + 1) % 256);
    end
    for (int k = 0; k <= HOLD; k++) tick(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_stall();
    int acc0;
    tick(1'b0, 1'b1, 3'd2, 1'b0);
    for (int k = 0; k < HOLD; k++) tick(1'b0, 1'b0, 3'd0, 1'b0);
    acc0 = int'(acc_cnt);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b1, 3'($urandom_range(7)), 1'b0);
      checks++;
      if (O !== 8'h04 || seen_in_ready !== 1'b0 || out_valid !== 1'b1 || int'(acc_cnt) != acc0) begin
        errors++;
        $display("FAIL stall%0d: O=%h rdy=%b ov=%b acc=%0d, required 04/0/1/%0d",
                 k, O, seen_in_ready, out_valid, acc_cnt, acc0);
      end
    end
    tick(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_reset_mid_dwell();
    tick(1'b0, 1'b1, 3'd7, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    checks++;
    if (O !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || acc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: O=%h ov=%b busy=%b acc=%0d, required 00/0/0/0", O, out_valid, busy, acc_cnt);
    end
    for (int k = 0; k <= HOLD; k++) tick(1'b0, 1'b0, 3'd0, 1'b0);
    checks++;
    if (O !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_discard: O=%h busy=%b, required 00/0", O, busy);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    // continuous valid/ready: one accept every HOLD+1 cycles, 257 accepts wraps to 1
    for (int k = 0; k < 257 * (HOLD + 1); k++) tick(1'b0, 1'b1, 3'(k % 8), 1'b1);
    checks++;
    if (acc_cnt !== 8'd1 || int'(acc_cnt) != m_acc) begin
      errors++;
      $display("FAIL acc_wrap: acc=%0d, required 1 (model %0d)", acc_cnt, m_acc);
    end
  endtask

  task automatic test_random();
    bit r;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(99) == 0);
      tick(r, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(3) != 0));
      checks++;
      if (O !== exp_o() || out_valid !== (m_active && m_age >= HOLD) || busy !== m_active
          || int'(acc_cnt) != m_acc || seen_in_ready !== exp_in_ready || $countones(O) > 1) begin
        errors++;
        $display("FAIL random%0d: O=%h ov=%b busy=%b acc=%0d rdy=%b, required %h/%b/%b/%0d/%b",
                 k, O, out_valid, busy, acc_cnt, seen_in_ready, exp_o(),
                 (m_active && m_age >= HOLD), m_active, m_acc, exp_in_ready);
      end
`ifdef SEQ_DEC_LOOPBACK_EN
      checks++;
      if (lb_err !== 1'b0) begin
        errors++;
        $display("FAIL lb_err%0d: got %b, required 0", k, lb_err);
      end
`endif
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_stall();
    test_reset_mid_dwell();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
